arb_mux: RTL and testbench
==========================

# arb_mux

Parametrised, registered N-way multiplexer with per-channel valid/ready handshake and a built-in arbiter. It generalises the CPU's fixed 2/3-input select muxes to any channel count and width. It replaces the external select with fixed-priority or round-robin arbitration, and adds a one-deep output register. It sits between multiple requesters (fetch, load/store, debug) and a single shared consumer such as the memory port.

## Interface
- `WIDTH`, 32: data width per channel.
- `N`, 4: number of input channels (2..16).
- `SELW`, 2: width of the `out_sel` index; set equal to clog2(N).
- `MODE`, 1: arbitration mode; 0 = fixed priority (channel 0 highest), 1 = round-robin.
- `clock` input 1: sole clock; all state updates on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `in_valid` input N: channel i offers data.
- `in_ready` output N: channel i data accepted this cycle.
- `in_data` input N*WIDTH: packed; channel i occupies bits [i*WIDTH +: WIDTH].
- `out_valid` output 1: output register holds an item.
- `out_ready` input 1: consumer takes the item this cycle.
- `out_data` output WIDTH: registered data.
- `out_sel` output SELW: index of the channel that supplied `out_data`.

## Operation
- Transfers:
  - Input transfer on channel i when `in_valid[i] & in_ready[i]` at a rising edge.
  - Output transfer when `out_valid & out_ready`.
- `load` = `!out_valid | out_ready`. The register is free, or is being drained in the same cycle.
- Grant, one-hot or zero, over the valid channels:
  - MODE 0: lowest-index valid channel.
  - MODE 1: first valid channel at or after `ptr`, searching upward with wrap from N-1 to 0.
- `in_ready[i]` = `grant[i] & load`. At most one bit is set, and it is set only when its `in_valid` bit is high.
- On an input transfer: `out_data` takes the granted channel's data, `out_sel` takes its index, and `out_valid` goes to 1.
- On an output transfer with no input transfer, `out_valid` goes to 0. `out_data` and `out_sel` hold their values.
- Simultaneous input and output transfers in the same cycle: the register is replaced and `out_valid` stays 1. This gives full throughput of one item per cycle.
- Round-robin pointer `ptr` (SELW bits):
  - On an input transfer from channel g, `ptr` becomes g+1, wrapping N-1 to 0.
  - `ptr` does not change when there is no input transfer.
  - With N not a power of two, `ptr` never takes a value of N or above.
- MODE 0 keeps no pointer state.
- Arbitration is non-locking. Grant is re-evaluated every cycle; the bench must still use valid-stays-asserted-until-ready sources.
- No valid inputs: grant is 0, all `in_ready` are 0, and the register drains normally.
- `in_data` of non-granted channels has no effect.

## Timing
- Reset (asynchronous assert, release synchronised by the caller): `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `ptr` = 0.
- `in_ready` is combinational from `in_valid`, `out_valid`, `out_ready` and `ptr`. It is 0 while `reset_n` is low.
- Latency: data accepted at edge k is visible on `out_data` right after edge k and can be consumed at edge k+1.
- `out_valid`, `out_data` and `out_sel` are purely registered, with no combinational path from the inputs.
- Backpressure: with `out_ready` low and `out_valid` high, all `in_ready` are 0, and `out_data` and `out_sel` remain stable.
- Reset asserted mid-stream: the held item is discarded and `ptr` returns to 0. After release, arbitration restarts from channel 0.

## Structure
- Shared header `cpu_defs.vh`:
  - Arbitration mode constants `ARB_FIXED` = 0 and `ARB_RR` = 1.
  - A clog2 helper macro, used to derive `SELW`.
- Sub-module `rr_arbiter` (parameters N, SELW, MODE):
  - Inputs: `in_valid`, `ptr`.
  - Outputs: one-hot `grant` and its binary index.
  - Purely combinational.
  - Implemented as a double-width masked priority search.
- `arb_mux` owns the output register, `ptr` and the handshake logic.

## Test plan
Defaults are WIDTH=4, N=3, SELW=2 unless stated.
- Reset: drive `reset_n` = 0 with all `in_valid` = 3'b111 → `in_ready` = 0, `out_valid` = 0, `out_data` = 0, `out_sel` = 0. After release, the first accepted item is channel 0.
- Select sweep: only `in_valid[1]`, data 4'h1, then only `in_valid[2]`, data 4'hF, with `out_ready` = 1 → `out_data` = 1 then F, `out_sel` = 1 then 2, one item per cycle.
- Round-robin fairness (MODE 1): all channels valid continuously with data 0/1/F, `out_ready` = 1 → `out_sel` sequence 0,1,2,0,1,2. MODE 0 under the same stimulus → `out_sel` = 0 every cycle.
- Backpressure: register holds 4'h1, `out_ready` = 0 for 3 cycles with all inputs valid → `in_ready` = 0, `out_data` = 1 held. Raising `out_ready` → simultaneous drain and reload on the same edge.
- Wrap with N=5 (SELW=3): last grant is 4, then only channel 1 valid → grant 1, `ptr` = 2, and `ptr` never reaches 5.
- Reset mid-stream: assert `reset_n` low while `out_valid` = 1 and `ptr` = 2 → outputs clear immediately. After release with all inputs valid, the first grant is channel 0.

Source files
------------

// File: rtl/arb_mux_pkg.sv
// Shared constants for arb_mux: arbitration mode encodings and a clog2 helper
// used to size the channel index.
package arb_mux_pkg;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/arb_mux_rr_arbiter.sv
// Combinational arbiter: one-hot grant plus binary index over the valid
// channels, fixed priority or round-robin starting at ptr.
module rr_arbiter
  import arb_mux_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N),
  parameter int MODE = ARB_RR
) (
  input  logic [N-1:0]    in_valid,
  input  logic [SELW-1:0] ptr,
  output logic [N-1:0]    grant,
  output logic [SELW-1:0] grant_idx
);

  logic [2*N-1:0]  w_dbl;
  logic [SELW-1:0] w_start;

  assign w_start = (MODE == ARB_RR) ? ptr : '0;
  assign w_dbl   = {in_valid, in_valid};

  // Search the doubled vector downward so the lowest unmasked bit at or
  // above w_start wins; the upper copy supplies the wrap-around.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int j = 2*N-1; j >= 0; j--) begin
      if (w_dbl[j] && (j >= int'(w_start))) begin
        grant            = '0;
        grant[j % N]     = 1'b1;
        grant_idx        = SELW'(j % N);
      end
    end
  end

endmodule

// File: rtl/arb_mux.sv
// Registered N-way mux with valid/ready per channel and a built-in arbiter.
// Handshake: a transfer happens on any edge where valid and ready are both high.
module arb_mux
  import arb_mux_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2(N),
  parameter int MODE  = ARB_RR
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_sel
);

  logic [N-1:0]     w_grant;
  logic [SELW-1:0]  w_gidx;
  logic [SELW-1:0]  r_ptr;
  logic [WIDTH-1:0] w_gdata;
  logic             w_load;
  logic             w_xfer;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic [SELW-1:0]  r_out_sel;

  rr_arbiter #(.N(N), .SELW(SELW), .MODE(MODE)) u_arb (
    .in_valid  (in_valid),
    .ptr       (r_ptr),
    .grant     (w_grant),
    .grant_idx (w_gidx)
  );

  // Register can take a new item when empty or being drained this cycle.
  assign w_load   = !r_out_valid | out_ready;
  assign w_xfer   = (|w_grant) & w_load;
  assign in_ready = w_grant & {N{w_load & reset_n}};
  assign w_gdata  = in_data[w_gidx*WIDTH +: WIDTH];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
    end else if (w_xfer) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_gdata;
      r_out_sel   <= w_gidx;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  generate
    if (MODE == ARB_RR) begin : g_rr
      logic [SELW-1:0] w_ptr_nxt;
      assign w_ptr_nxt = (w_gidx == SELW'(N-1)) ? '0 : w_gidx + 1'b1;
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    r_ptr <= '0;
        else if (w_xfer) r_ptr <= w_ptr_nxt;
      end
    end else begin : g_fixed
      assign r_ptr = '0;
    end
  endgenerate

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

// File: tb/tb_arb_mux.sv
// Bench for arb_mux: vector table on a 3-channel round-robin instance, directed
// fixed-priority and 5-channel wrap sequences, then a randomised scoreboard run.
module tb_arb_mux;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  // 3-channel round-robin
  logic [2:0]  rr_v, rr_rdy;
  logic [11:0] rr_d;
  logic        rr_ordy, rr_ov;
  logic [3:0]  rr_od;
  logic [1:0]  rr_os;
  // 3-channel fixed priority
  logic [2:0]  fx_v, fx_rdy;
  logic [11:0] fx_d;
  logic        fx_ordy, fx_ov;
  logic [3:0]  fx_od;
  logic [1:0]  fx_os;
  // 5-channel round-robin
  logic [4:0]  n5_v, n5_rdy;
  logic [19:0] n5_d;
  logic        n5_ordy, n5_ov;
  logic [3:0]  n5_od;
  logic [2:0]  n5_os;

  arb_mux #(.WIDTH(4), .N(3), .SELW(2), .MODE(1)) u_rr (
    .clock(clk), .reset_n(rst_n), .in_valid(rr_v), .in_ready(rr_rdy), .in_data(rr_d),
    .out_valid(rr_ov), .out_ready(rr_ordy), .out_data(rr_od), .out_sel(rr_os));
  arb_mux #(.WIDTH(4), .N(3), .SELW(2), .MODE(0)) u_fx (
    .clock(clk), .reset_n(rst_n), .in_valid(fx_v), .in_ready(fx_rdy), .in_data(fx_d),
    .out_valid(fx_ov), .out_ready(fx_ordy), .out_data(fx_od), .out_sel(fx_os));
  arb_mux #(.WIDTH(4), .N(5), .SELW(3), .MODE(1)) u_n5 (
    .clock(clk), .reset_n(rst_n), .in_valid(n5_v), .in_ready(n5_rdy), .in_data(n5_d),
    .out_valid(n5_ov), .out_ready(n5_ordy), .out_data(n5_od), .out_sel(n5_os));

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];  // {sel, data}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_pop(input string name);
    logic [5:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: output transfer %0h with empty expected queue", name, {rr_os, rr_od});
    end else begin
      e = exp_q.pop_front();
      chk(name, {26'd0, rr_os, rr_od}, {26'd0, e});
    end
  endtask

  function automatic int oh_idx(input logic [2:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < 3; i++) if (oh[i]) r = i;
    return r;
  endfunction

  typedef struct {
    logic       rst;
    logic [2:0] v;
    logic       ordy;
    logic [2:0] rdy;
    logic       ov;
    logic [1:0] sel;
    logic [3:0] dat;
  } vec_t;
  vec_t tbl[22];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    rr_v = '0; rr_ordy = 1'b0; rr_d = 12'hF10;
    fx_v = '0; fx_ordy = 1'b0; fx_d = 12'hF10;
    n5_v = '0; n5_ordy = 1'b0;
    for (int i = 0; i < 5; i++) n5_d[i*4 +: 4] = 4'(i + 8);

    //            rst  v       ordy  rdy     ov    sel   dat
    tbl[0]  = '{1'b0, 3'b111, 1'b0, 3'b000, 1'b0, 2'd0, 4'h0};  // reset with all valid
    tbl[1]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 4'h0};  // fairness 0,1,2,0,1,2
    tbl[2]  = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 4'h1};
    tbl[3]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 4'hF};
    tbl[4]  = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 4'h0};
    tbl[5]  = '{1'b1, 3'b111, 1'b1, 3'b010, 1'b1, 2'd1, 4'h1};
    tbl[6]  = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 4'hF};
    tbl[7]  = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 4'h1};  // select sweep
    tbl[8]  = '{1'b1, 3'b100, 1'b1, 3'b100, 1'b1, 2'd2, 4'hF};
    tbl[9]  = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 4'h1};  // load 1, then stall
    tbl[10] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 4'h1};
    tbl[11] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 4'h1};
    tbl[12] = '{1'b1, 3'b111, 1'b0, 3'b000, 1'b1, 2'd1, 4'h1};
    tbl[13] = '{1'b1, 3'b111, 1'b1, 3'b100, 1'b1, 2'd2, 4'hF};  // drain + reload
    tbl[14] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2, 4'hF};  // drain, hold data
    tbl[15] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 2'd2, 4'hF};
    tbl[16] = '{1'b1, 3'b001, 1'b0, 3'b001, 1'b1, 2'd0, 4'h0};  // empty register loads
    tbl[17] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b1, 2'd0, 4'h0};
    tbl[18] = '{1'b1, 3'b010, 1'b1, 3'b010, 1'b1, 2'd1, 4'h1};  // ptr now 2
    tbl[19] = '{1'b0, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, 4'h0};  // reset mid-stream
    tbl[20] = '{1'b1, 3'b111, 1'b1, 3'b001, 1'b1, 2'd0, 4'h0};  // restart at channel 0
    tbl[21] = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 2'd0, 4'h0};

    for (int r = 0; r < 22; r++) begin
      @(negedge clk);
      rst_n = tbl[r].rst; rr_v = tbl[r].v; rr_ordy = tbl[r].ordy;
      #1;
      chk($sformatf("row%0d in_ready", r), 32'(rr_rdy), 32'(tbl[r].rdy));
      if (!tbl[r].rst) begin
        chk($sformatf("row%0d async_clear", r), {29'd0, rr_ov, rr_os}, 32'd0);
        chk($sformatf("row%0d async_data", r), 32'(rr_od), 32'd0);
        exp_q.delete();
      end else if (rr_ov && rr_ordy) begin
        sb_pop($sformatf("row%0d sb_out", r));
      end
      if (tbl[r].rdy != 3'b000)
        exp_q.push_back({2'(oh_idx(tbl[r].rdy)), rr_d[oh_idx(tbl[r].rdy)*4 +: 4]});
      @(posedge clk); #1;
      chk($sformatf("row%0d out_valid", r), 32'(rr_ov), 32'(tbl[r].ov));
      chk($sformatf("row%0d out_sel", r), 32'(rr_os), 32'(tbl[r].sel));
      chk($sformatf("row%0d out_data", r), 32'(rr_od), 32'(tbl[r].dat));
    end
    chk("tbl sb_drain", exp_q.size(), 32'd0);

    // Fixed priority: channel 0 wins every cycle.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      fx_v = 3'b111; fx_ordy = 1'b1;
      #1 chk($sformatf("fx%0d in_ready", c), 32'(fx_rdy), 32'd1);
      @(posedge clk); #1;
      chk($sformatf("fx%0d out_sel", c), 32'(fx_os), 32'd0);
      chk($sformatf("fx%0d out_data", c), {27'd0, fx_ov, fx_od}, 32'h10);
    end
    @(negedge clk); fx_v = '0; fx_ordy = 1'b0;

    // Five channels: sweep 0..4, wrap, then only channel 1.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n5_v = (c < 5) ? 5'b11111 : 5'b00010; n5_ordy = 1'b1;
      #1 chk($sformatf("n5_%0d in_ready", c), 32'(n5_rdy), (c < 5) ? (32'd1 << c) : 32'd2);
      @(posedge clk); #1;
      chk($sformatf("n5_%0d out_sel", c), 32'(n5_os), (c < 5) ? 32'(c) : 32'd1);
      chk($sformatf("n5_%0d out_data", c), 32'(n5_od), (c < 5) ? 32'(c + 8) : 32'd9);
      chk($sformatf("n5_%0d ptr", c), 32'(u_n5.r_ptr), (c < 4) ? 32'(c + 1) : ((c == 4) ? 32'd0 : 32'd2));
    end
    @(negedge clk); n5_v = '0;

    // Randomised run with held-valid sources and a reference arbiter.
    rst_n = 1'b0; rr_v = '0; rr_ordy = 1'b0;
    exp_q.delete();
    @(negedge clk); rst_n = 1'b1;
    begin
      int m_ptr, g;
      logic m_ov, load;
      logic [2:0] exp_rdy;
      m_ptr = 0; m_ov = 1'b0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk);
        for (int ch = 0; ch < 3; ch++) begin
          if (!rr_v[ch]) begin
            rr_d[ch*4 +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) rr_v[ch] = 1'b1;
          end
        end
        rr_ordy = ($urandom_range(0, 3) != 0);
        #1;
        g = -1;
        for (int k = 0; k < 3; k++) if (g < 0 && rr_v[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
        load = !m_ov || rr_ordy;
        exp_rdy = (load && g >= 0) ? 3'(1 << g) : 3'b000;
        chk($sformatf("rnd%0d in_ready", c), 32'(rr_rdy), 32'(exp_rdy));
        if (m_ov && rr_ordy) sb_pop($sformatf("rnd%0d sb_out", c));
        if (load && g >= 0) exp_q.push_back({2'(g), rr_d[g*4 +: 4]});
        @(posedge clk); #1;
        if (load && g >= 0) begin
          m_ov = 1'b1; m_ptr = (g + 1) % 3; rr_v[g] = 1'b0;
        end else if (rr_ordy) begin
          m_ov = 1'b0;
        end
        chk($sformatf("rnd%0d out_valid", c), 32'(rr_ov), 32'(m_ov));
        chk($sformatf("rnd%0d ptr", c), 32'(u_rr.r_ptr), 32'(m_ptr));
      end
      chk("rnd sb_level", exp_q.size(), m_ov ? 32'd1 : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
